// File: rtl/override_release_reg.sv
// Register cell with a normal write path and an override path that pins it to a live source.
// Optional OVR_WRITE_SHADOW_EN: on release, replay the last write that was dropped while overridden.
module override_release_reg #(
  parameter int WIDTH = 32,
  parameter int BLK_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             assign_req,
  input  logic             deassign_req,
  input  logic             ovr_src_sel,
  input  logic [WIDTH-1:0] ovr_data,
  output logic [WIDTH-1:0] value,
  output logic             overridden,
  output logic             ack,
  output logic             err,
  output logic [BLK_W-1:0] blocked_cnt
);
  typedef enum logic {FREE = 1'b0, HELD = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, r_value, w_src, w_new_src, w_rel_data;
  logic [BLK_W-1:0] r_blk;
  logic             r_sel, r_ack, r_err;
  logic             w_ack, w_err, w_drop, w_load_new, w_track, w_wr, w_release, w_rel_load;

  // Tracking uses the latched selection; a fresh assign uses the requested one.
  assign w_src     = r_sel ? ovr_data : r_cnt;
  assign w_new_src = ovr_src_sel ? ovr_data : r_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= FREE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FREE:    if (assign_req)   w_state_nxt = HELD;
      HELD:    if (deassign_req) w_state_nxt = FREE;
      default: w_state_nxt = FREE;
    endcase
  end

  always_comb begin
    w_ack      = 1'b0;
    w_err      = 1'b0;
    w_drop     = 1'b0;
    w_load_new = 1'b0;
    w_track    = 1'b0;
    w_wr       = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      FREE: begin
        if (assign_req) begin
          w_ack      = 1'b1;
          w_load_new = 1'b1;
          w_drop     = wr_en;
        end else begin
          w_wr  = wr_en;
          w_err = deassign_req;
        end
      end
      HELD: begin
        w_drop = wr_en;
        if (deassign_req) begin
          w_ack     = 1'b1;
          w_release = 1'b1;
        end else if (assign_req) begin
          w_ack      = 1'b1;
          w_load_new = 1'b1;
        end else begin
          w_track = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef OVR_WRITE_SHADOW_EN
  logic [WIDTH-1:0] r_shadow;
  logic             r_shadow_vld;

  // A write coincident with the release is the newest dropped write, so it wins.
  assign w_rel_load = w_release & (w_drop | r_shadow_vld);
  assign w_rel_data = w_drop ? wr_data : r_shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
    end else if (w_release) begin
      r_shadow_vld <= 1'b0;
    end else if (w_drop) begin
      r_shadow     <= wr_data;
      r_shadow_vld <= 1'b1;
    end
  end
`else
  assign w_rel_load = 1'b0;
  assign w_rel_data = r_value;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_value <= '0;
      r_blk   <= '0;
      r_sel   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cnt <= r_cnt + WIDTH'(1);
      r_ack <= w_ack;
      r_err <= w_err;
      if (w_load_new) r_sel <= ovr_src_sel;
      if (w_load_new)      r_value <= w_new_src;
      else if (w_track)    r_value <= w_src;
      else if (w_wr)       r_value <= wr_data;
      else if (w_rel_load) r_value <= w_rel_data;
      if (w_drop && r_blk != {BLK_W{1'b1}}) r_blk <= r_blk + BLK_W'(1);
    end
  end

  assign value       = r_value;
  assign overridden  = (r_state == HELD);
  assign ack         = r_ack;
  assign err         = r_err;
  assign blocked_cnt = r_blk;
endmodule

// File: tb/tb_override_release_reg.sv
// Bench for override_release_reg: vector table, hand-written corner sequences, then
// randomized traffic against a rule-level reference model.
module tb_override_release_reg;
  localparam int WIDTH = 32;
  localparam int BLK_W = 2;
`ifdef OVR_WRITE_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, wr_en, assign_req, deassign_req, ovr_src_sel;
  logic [WIDTH-1:0] wr_data, ovr_data, value;
  logic             overridden, ack, err;
  logic [BLK_W-1:0] blocked_cnt;

  always #5 clk = ~clk;

  override_release_reg #(.WIDTH(WIDTH), .BLK_W(BLK_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .assign_req(assign_req), .deassign_req(deassign_req),
    .ovr_src_sel(ovr_src_sel), .ovr_data(ovr_data),
    .value(value), .overridden(overridden), .ack(ack), .err(err),
    .blocked_cnt(blocked_cnt)
  );

  int nvec = 0;
  int nfail = 0;

  // Reference model: state of the cell as described by its rules.
  bit               m_held, m_sel, m_ack, m_err, m_shv;
  logic [WIDTH-1:0] m_val, m_cnt, m_sh;
  int               m_blk;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit we, input logic [WIDTH-1:0] wd,
                      input bit asg, input bit dasg, input bit sel, input logic [WIDTH-1:0] od);
    logic [WIDTH-1:0] src, nsrc;
    bit dropped;
    reset = rst; wr_en = we; wr_data = wd; assign_req = asg;
    deassign_req = dasg; ovr_src_sel = sel; ovr_data = od;
    if (rst) begin
      m_held = 0; m_sel = 0; m_ack = 0; m_err = 0; m_shv = 0;
      m_val = '0; m_cnt = '0; m_sh = '0; m_blk = 0;
    end else begin
      src  = m_sel ? od : m_cnt;
      nsrc = sel ? od : m_cnt;
      m_ack = 0; m_err = 0; dropped = 0;
      if (!m_held) begin
        if (asg) begin
          m_sel = sel; m_val = nsrc; m_held = 1; m_ack = 1; dropped = we;
          if (SH && we) begin m_sh = wd; m_shv = 1; end
        end else begin
          if (we) m_val = wd;
          if (dasg) m_err = 1;
        end
      end else begin
        dropped = we;
        if (dasg) begin
          m_held = 0; m_ack = 1;
          if (SH) begin
            if (we) m_val = wd;
            else if (m_shv) m_val = m_sh;
            m_shv = 0;
          end
        end else begin
          if (asg) begin m_sel = sel; m_val = nsrc; m_ack = 1; end
          else m_val = src;
          if (SH && we) begin m_sh = wd; m_shv = 1; end
        end
      end
      if (dropped && m_blk < (1 << BLK_W) - 1) m_blk++;
      m_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, '0);
  endtask

  typedef struct {
    bit rst, we; logic [WIDTH-1:0] wd; bit asg, dasg, sel; logic [WIDTH-1:0] od;
    logic [WIDTH-1:0] ev; bit eo, ea, ee; logic [BLK_W-1:0] eb;
  } vec_t;

  function automatic vec_t mk(bit rst, bit we, logic [WIDTH-1:0] wd, bit asg, bit dasg, bit sel,
                              logic [WIDTH-1:0] od, logic [WIDTH-1:0] ev, bit eo, bit ea, bit ee,
                              logic [BLK_W-1:0] eb);
    vec_t v;
    v.rst = rst; v.we = we; v.wd = wd; v.asg = asg; v.dasg = dasg; v.sel = sel; v.od = od;
    v.ev = ev; v.eo = eo; v.ea = ea; v.ee = ee; v.eb = eb;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    //            rst we wd    asg dasg sel od  | value ovr ack err blk
    tbl[0]  = mk(1, 0, 0,    0, 0, 0, 0,   0,    0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 'h55, 0, 0, 0, 0,   'h55, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,    0, 1, 0, 0,   'h55, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0,    0, 0, 0, 0,   'h55, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0,    1, 0, 1, 1,   1,    1, 1, 0, 0);
    tbl[5]  = mk(0, 1, 0,    0, 0, 0, 1,   1,    1, 0, 0, 1);
    tbl[6]  = mk(0, 1, 0,    0, 0, 0, 1,   1,    1, 0, 0, 2);
    tbl[7]  = mk(0, 1, 0,    0, 0, 0, 1,   1,    1, 0, 0, 3);
    tbl[8]  = mk(0, 1, 0,    0, 0, 0, 1,   1,    1, 0, 0, 3);
    tbl[9]  = mk(0, 0, 0,    0, 0, 0, 1,   1,    1, 0, 0, 3);
    tbl[10] = mk(0, 0, 0,    1, 1, 0, 2,   SH ? 0 : 1, 0, 1, 0, 3);
    tbl[11] = mk(0, 1, 0,    0, 0, 0, 2,   0,    0, 0, 0, 3);
    tbl[12] = mk(1, 0, 0,    0, 0, 0, 0,   0,    0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].we, tbl[i].wd, tbl[i].asg, tbl[i].dasg, tbl[i].sel, tbl[i].od);
      chk($sformatf("tbl%0d.value", i), value, tbl[i].ev);
      chk($sformatf("tbl%0d.overridden", i), WIDTH'(overridden), WIDTH'(tbl[i].eo));
      chk($sformatf("tbl%0d.ack", i), WIDTH'(ack), WIDTH'(tbl[i].ea));
      chk($sformatf("tbl%0d.err", i), WIDTH'(err), WIDTH'(tbl[i].ee));
      chk($sformatf("tbl%0d.blocked", i), WIDTH'(blocked_cnt), WIDTH'(tbl[i].eb));
    end

    // Counter source: assign when cnt=5, track, release when cnt=20 holds 19.
    step(1, 0, 0, 0, 0, 0, 0);
    idle(5);
    step(0, 0, 0, 1, 0, 0, 'hdead);
    chk("cnt.assign_value", value, 5);
    chk("cnt.assign_ack", WIDTH'(ack), 1);
    idle(1);
    chk("cnt.track6", value, 6);
    chk("cnt.ack_drop", WIDTH'(ack), 0);
    idle(1);
    chk("cnt.track7", value, 7);
    idle(12);
    chk("cnt.track19", value, 19);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("cnt.release_value", value, 19);
    chk("cnt.release_ovr", WIDTH'(overridden), 0);
    chk("cnt.release_ack", WIDTH'(ack), 1);
    idle(1);
    chk("cnt.hold_value", value, 19);

    // Reset in the middle of an override.
    step(0, 0, 0, 1, 0, 1, 'h1234);
    step(0, 1, 9, 0, 0, 0, 'h1234);
    step(0, 1, 9, 0, 0, 0, 'h1234);
    step(1, 1, 9, 0, 0, 0, 'h1234);
    chk("rst_held.value", value, 0);
    chk("rst_held.ovr", WIDTH'(overridden), 0);
    chk("rst_held.blocked", WIDTH'(blocked_cnt), 0);
    chk("rst_held.ack", WIDTH'(ack), 0);

    // Dropped writes 0xA, 0xB then release.
    step(0, 0, 0, 1, 0, 1, 'h77);
    step(0, 1, 'hA, 0, 0, 0, 'h77);
    step(0, 1, 'hB, 0, 0, 0, 'h77);
    step(0, 0, 0, 0, 1, 0, 'h99);
    chk("shadow.release_value", value, SH ? 'hB : 'h77);
    chk("shadow.blocked", WIDTH'(blocked_cnt), 2);

    // Randomized traffic against the model.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 40), $urandom,
           ($urandom_range(99) < 10), ($urandom_range(99) < 10), $urandom_range(1), $urandom);
      chk($sformatf("rnd%0d.value", i), value, m_val);
      chk($sformatf("rnd%0d.overridden", i), WIDTH'(overridden), WIDTH'(m_held));
      chk($sformatf("rnd%0d.ack", i), WIDTH'(ack), WIDTH'(m_ack));
      chk($sformatf("rnd%0d.err", i), WIDTH'(err), WIDTH'(m_err));
      chk($sformatf("rnd%0d.blocked", i), WIDTH'(blocked_cnt), WIDTH'(m_blk));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/override_release_reg.md
Name: override_release_reg

Overview:
- Synthesizable register with a normal write path plus a procedural-override path.
- While overridden, the register continuously tracks a selected source and rejects normal writes.
- On release, it keeps the last tracked value and accepts normal writes again.
- Used as a control/status register cell that diagnostics logic can pin to a live source (free-running counter or external bus) and later release.

Parameters:
- WIDTH, 32, width of stored value, write data, override data and internal counter.
- BLK_W, 8, width of the saturating blocked-write counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- wr_en  input  1  normal write strobe
- wr_data  input  WIDTH  normal write data
- assign_req  input  1  override request (single-cycle command)
- deassign_req  input  1  release request (single-cycle command)
- ovr_src_sel  input  1  override source: 0 = internal counter, 1 = ovr_data; sampled with assign_req
- ovr_data  input  WIDTH  external override source
- value  output  WIDTH  stored register value
- overridden  output  1  high while in HELD
- ack  output  1  one-cycle pulse: command accepted
- err  output  1  one-cycle pulse: command rejected
- blocked_cnt  output  BLK_W  number of writes dropped due to override, saturating

Behaviour:
- Single clock domain; reset is synchronous and active-high. All outputs registered.
- Reset, including mid-override:
  - state FREE, value 0, internal counter 0, blocked_cnt 0.
  - overridden 0, ack 0, err 0, src_sel_q 0, shadow invalid.
- Internal counter cnt_q: +1 every non-reset edge, wraps 2^WIDTH-1 -> 0.
- src = ovr_data if src_sel_q else cnt_q, using current (pre-increment) cnt_q.
- FREE state, priority order at each edge:
  - assign_req:
    - src_sel_q <= ovr_src_sel.
    - value <= the newly selected source at this same edge (override takes effect immediately).
    - state -> HELD, ack pulse.
    - A coincident wr_en is dropped and counted in blocked_cnt.
  - else wr_en: value <= wr_data.
  - deassign_req alone: err pulse, no state change. If wr_en is also asserted, the write still completes.
- HELD state, priority order at each edge:
  - deassign_req (wins over a coincident assign_req):
    - value NOT updated at this edge; it retains the sample from the previous edge.
    - state -> FREE, ack pulse. A coincident wr_en is dropped and counted.
  - else assign_req: re-assign.
    - src_sel_q <= ovr_src_sel; value <= new source; ack pulse; stays HELD.
  - else: value <= src every edge (1-edge tracking latency vs source).
  - wr_en during HELD: dropped; blocked_cnt +1, saturating at 2^BLK_W-1.
- overridden = (state == HELD), registered with state.
- ack and err are never high together, and each is high for exactly 1 cycle per command.
- Counter-source consequence: after a deassign at the edge where cnt_q = N, value holds N-1.

Optional Feature:
- Macro: OVR_WRITE_SHADOW_EN.
- Defined:
  - Each write dropped during HELD, including one coincident with deassign_req, is stored in a shadow register (last write wins) and marks the shadow valid.
  - On deassign: value <= shadow if valid, otherwise the retained value is kept. Shadow is then invalidated.
  - blocked_cnt still counts dropped writes.
  - A write dropped in FREE by a coincident assign_req IS shadowed.
- Not defined: no shadow register; dropped writes are discarded; release always retains the last tracked value.

Test Plan:
- Reset, wr_en=1 wr_data=0x55 -> value=0x55 next cycle, overridden=0, blocked_cnt=0.
- After reset, assign_req with sel=0 on the edge where cnt_q=5 -> value=5, ack=1 for 1 cycle; value then 6, 7, ... each edge. deassign_req at the edge where cnt_q=20 -> value stays 19, overridden=0.
- HELD with sel=1, ovr_data=1 -> value=1. Issue 3 writes of 0 -> value stays 1, blocked_cnt=3. After deassign, wr_data=0 -> value=0.
- deassign_req in FREE -> err=1 one cycle, ack=0. Simultaneous assign_req+deassign_req in HELD -> release wins, state FREE.
- BLK_W=2, 5 writes during HELD -> blocked_cnt saturates at 3. reset asserted mid-HELD -> value=0, overridden=0, blocked_cnt=0.
- OVR_WRITE_SHADOW_EN defined: HELD, writes 0xA then 0xB, deassign -> value=0xB. Undefined: same stimulus -> value = last tracked sample.
